// File: rtl/regfile_2r1w.sv
// ----------------------------------------------------------------------------
// regfile_2r1w
//
// General-purpose register file for the MIPS-style CPU: 2**ADDR_W registers of
// DATA_W bits, two combinational read ports, one synchronous write port and one
// debug read port. Register 0 is hardwired to zero and holds no storage.
//
// Ports:
//   clk       in   1       system clock, all state updates on the rising edge
//   rst       in   1       synchronous active-high reset (clears regs, wr_cnt)
//   raddr1    in   ADDR_W  read port 1 address (rs)
//   raddr2    in   ADDR_W  read port 2 address (rt)
//   rdata1    out  DATA_W  read port 1 data (zero latency, optional forwarding)
//   rdata2    out  DATA_W  read port 2 data (zero latency, optional forwarding)
//   we        in   1       write enable (RegWrite)
//   waddr     in   ADDR_W  write address from the destination-select mux
//   wdata     in   DATA_W  write-back data
//   dbg_addr  in   ADDR_W  debug read address
//   dbg_data  out  DATA_W  debug read data, never forwarded
//   wr_cnt    out  16      committed writes since reset, saturating at 16'hFFFF
// ----------------------------------------------------------------------------
module regfile_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [15:0]       wr_cnt
);

    localparam int NREG = 2 ** ADDR_W;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Storage exists only for entries 1..NREG-1.
    logic [DATA_W-1:0] r_regs [1:NREG-1];
    logic [15:0]       r_wr_cnt;

    // Read view of the file with entry 0 tied to zero, so every read port can
    // index it directly without a separate address-0 check.
    logic [DATA_W-1:0] w_regs [0:NREG-1];
    logic              w_commit;
    logic              w_fwd1;
    logic              w_fwd2;

    assign w_regs[0] = '0;

    for (genvar gi = 1; gi < NREG; gi++) begin : g_view
        assign w_regs[gi] = r_regs[gi];
    end

    // A write to address 0 is discarded and does not count.
    assign w_commit = we && (waddr != '0);

    // Forwarding only when the write will actually commit at the coming edge:
    // a pending reset wins over the write, so it must not be forwarded either.
    assign w_fwd1 = (BYPASS != 0) && w_commit && !rst && (waddr == raddr1);
    assign w_fwd2 = (BYPASS != 0) && w_commit && !rst && (waddr == raddr2);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the array is explicitly reset because the architecture
            // requires every register to read 0 after reset; a plain RAM macro
            // could not be used for this storage.
            for (int i = 1; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_cnt <= '0;
        end else if (w_commit) begin
            r_regs[waddr] <= wdata;
            if (r_wr_cnt != CNT_MAX) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
        end
    end

    // NOTE: every output gets its default first, so no path leaves a value
    // unassigned and no latch is inferred.
    always_comb begin
        rdata1   = w_regs[raddr1];
        rdata2   = w_regs[raddr2];
        dbg_data = w_regs[dbg_addr];
        if (w_fwd1) begin
            rdata1 = wdata;
        end
        if (w_fwd2) begin
            rdata2 = wdata;
        end
    end

    assign wr_cnt = r_wr_cnt;

endmodule

// File: tb/tb_regfile_2r1w.sv
// ----------------------------------------------------------------------------
// tb_regfile_2r1w
//
// Self-checking bench for regfile_2r1w. Two instances share all inputs: one
// with forwarding enabled and one without. A behavioural model (a plain array
// plus a saturating integer count) predicts every output.
// ----------------------------------------------------------------------------
module tb_regfile_2r1w;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [AW-1:0] raddr1, raddr2, waddr, dbg_addr;
    logic [DW-1:0] wdata;

    logic [DW-1:0] b_rdata1, b_rdata2, b_dbg;
    logic [15:0]   b_cnt;
    logic [DW-1:0] n_rdata1, n_rdata2, n_dbg;
    logic [15:0]   n_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model
    logic [DW-1:0] m_regs [NR];
    int            m_cnt;

    always #5 clk = ~clk;

    regfile_2r1w #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) u_dut_byp (
        .clk(clk), .rst(rst),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(b_rdata1), .rdata2(b_rdata2),
        .we(we), .waddr(waddr), .wdata(wdata),
        .dbg_addr(dbg_addr), .dbg_data(b_dbg), .wr_cnt(b_cnt)
    );

    regfile_2r1w #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) u_dut_nb (
        .clk(clk), .rst(rst),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(n_rdata1), .rdata2(n_rdata2),
        .we(we), .waddr(waddr), .wdata(wdata),
        .dbg_addr(dbg_addr), .dbg_data(n_dbg), .wr_cnt(n_cnt)
    );

    // Expected value of a read port for the current inputs.
    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (a == '0) return '0;
        if (byp && we && !rst && (waddr == a)) return wdata;
        return m_regs[a];
    endfunction

    function automatic logic [DW-1:0] exp_dbg(input logic [AW-1:0] a);
        if (a == '0) return '0;
        return m_regs[a];
    endfunction

    // One rising edge: advance the model with the inputs held across it, then
    // settle 1 time unit past the edge before anything is driven or sampled.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NR; i++) m_regs[i] = '0;
            m_cnt = 0;
        end else if (we && waddr != '0) begin
            m_regs[waddr] = wdata;
            if (m_cnt < 65535) m_cnt++;
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        raddr1 = '0; raddr2 = '0; dbg_addr = '0;
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; we = 1'b1; waddr = 5'd7; wdata = 32'hCAFE_F00D;
        tick(); tick();
        idle_inputs();
        #1;
        n_cmp++; if (b_cnt !== 16'd0) begin n_mis++; $display("FAIL reset_cnt got=%h exp=0000", b_cnt); end
        n_cmp++; if (n_cnt !== 16'd0) begin n_mis++; $display("FAIL reset_cnt_nb got=%h exp=0000", n_cnt); end
        for (int a = 0; a < NR; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(NR - 1 - a); dbg_addr = 5'(a);
            #1;
            n_cmp++; if (b_rdata1 !== 32'd0 || b_rdata2 !== 32'd0 || b_dbg !== 32'd0) begin
                n_mis++; $display("FAIL reset_zero addr=%0d got=%h/%h/%h exp=0", a, b_rdata1, b_rdata2, b_dbg);
            end
            n_cmp++; if (n_rdata1 !== 32'd0 || n_rdata2 !== 32'd0 || n_dbg !== 32'd0) begin
                n_mis++; $display("FAIL reset_zero_nb addr=%0d got=%h/%h/%h exp=0", a, n_rdata1, n_rdata2, n_dbg);
            end
        end

        // Preload reg5, then reset: until the edge the old content stays visible.
        write_reg(5'd5, 32'hDEAD_BEEF);
        rst = 1'b1; raddr1 = 5'd5; dbg_addr = 5'd5;
        #1;
        n_cmp++; if (b_rdata1 !== 32'hDEAD_BEEF) begin n_mis++; $display("FAIL reset_pre_edge got=%h exp=deadbeef", b_rdata1); end
        n_cmp++; if (b_dbg !== 32'hDEAD_BEEF) begin n_mis++; $display("FAIL reset_pre_edge_dbg got=%h exp=deadbeef", b_dbg); end
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (b_rdata1 !== 32'd0) begin n_mis++; $display("FAIL reset_clear_rd1 got=%h exp=0", b_rdata1); end
        n_cmp++; if (b_dbg !== 32'd0) begin n_mis++; $display("FAIL reset_clear_dbg got=%h exp=0", b_dbg); end
        n_cmp++; if (b_cnt !== 16'd0) begin n_mis++; $display("FAIL reset_clear_cnt got=%h exp=0000", b_cnt); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_basic_write();
        logic [15:0] cnt0;
        cnt0 = 16'(m_cnt);
        write_reg(5'd8, 32'h1234_5678);
        raddr1 = 5'd8; raddr2 = 5'd8; dbg_addr = 5'd8;
        #1;
        n_cmp++; if (b_rdata1 !== 32'h1234_5678 || b_rdata2 !== 32'h1234_5678) begin
            n_mis++; $display("FAIL basic_rd got=%h/%h exp=12345678", b_rdata1, b_rdata2);
        end
        n_cmp++; if (b_dbg !== 32'h1234_5678) begin n_mis++; $display("FAIL basic_dbg got=%h exp=12345678", b_dbg); end
        n_cmp++; if (n_rdata1 !== 32'h1234_5678) begin n_mis++; $display("FAIL basic_rd_nb got=%h exp=12345678", n_rdata1); end
        n_cmp++; if (b_cnt !== cnt0 + 16'd1) begin n_mis++; $display("FAIL basic_cnt got=%h exp=%h", b_cnt, cnt0 + 16'd1); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_r0();
        logic [15:0] cnt0;
        cnt0 = 16'(m_cnt);
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        raddr1 = 5'd0; raddr2 = 5'd0; dbg_addr = 5'd0;
        #1;
        n_cmp++; if (b_rdata1 !== 32'd0 || b_rdata2 !== 32'd0) begin
            n_mis++; $display("FAIL r0_during got=%h/%h exp=0", b_rdata1, b_rdata2);
        end
        tick();
        we = 1'b0;
        #1;
        n_cmp++; if (b_rdata1 !== 32'd0 || b_dbg !== 32'd0 || n_rdata1 !== 32'd0) begin
            n_mis++; $display("FAIL r0_after got=%h/%h/%h exp=0", b_rdata1, b_dbg, n_rdata1);
        end
        n_cmp++; if (b_cnt !== cnt0) begin n_mis++; $display("FAIL r0_cnt got=%h exp=%h", b_cnt, cnt0); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_bypass();
        write_reg(5'd3, 32'h0000_1111);
        we = 1'b1; waddr = 5'd3; wdata = 32'h0000_2222;
        raddr1 = 5'd3; raddr2 = 5'd3; dbg_addr = 5'd3;
        #1;
        n_cmp++; if (b_rdata2 !== 32'h0000_2222 || b_rdata1 !== 32'h0000_2222) begin
            n_mis++; $display("FAIL bypass_fwd got=%h/%h exp=00002222", b_rdata1, b_rdata2);
        end
        n_cmp++; if (b_dbg !== 32'h0000_1111) begin n_mis++; $display("FAIL bypass_dbg got=%h exp=00001111", b_dbg); end
        n_cmp++; if (n_rdata2 !== 32'h0000_1111) begin n_mis++; $display("FAIL bypass_off got=%h exp=00001111", n_rdata2); end
        tick();
        we = 1'b0;
        #1;
        n_cmp++; if (b_rdata1 !== 32'h0000_2222 || b_rdata2 !== 32'h0000_2222 || b_dbg !== 32'h0000_2222) begin
            n_mis++; $display("FAIL bypass_after got=%h/%h/%h exp=00002222", b_rdata1, b_rdata2, b_dbg);
        end
        n_cmp++; if (n_rdata2 !== 32'h0000_2222) begin n_mis++; $display("FAIL bypass_after_nb got=%h exp=00002222", n_rdata2); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_vs_write();
        write_reg(5'd9, 32'h0000_5555);
        rst = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h0000_ABCD;
        raddr1 = 5'd9; dbg_addr = 5'd9;
        #1;
        // A write that reset will drop must not be forwarded.
        n_cmp++; if (b_rdata1 !== 32'h0000_5555) begin n_mis++; $display("FAIL rstwr_no_fwd got=%h exp=00005555", b_rdata1); end
        tick();
        idle_inputs();
        raddr1 = 5'd9; dbg_addr = 5'd9;
        #1;
        n_cmp++; if (b_rdata1 !== 32'd0 || b_dbg !== 32'd0) begin
            n_mis++; $display("FAIL rstwr_reg9 got=%h/%h exp=0", b_rdata1, b_dbg);
        end
        n_cmp++; if (b_cnt !== 16'd0) begin n_mis++; $display("FAIL rstwr_cnt got=%h exp=0000", b_cnt); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst    = ($urandom_range(0, 99) == 0);
            we     = ($urandom_range(0, 1) == 1);
            waddr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            wdata  = $urandom;
            raddr1 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
            raddr2 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
            dbg_addr = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
            #1;
            n_cmp++; if (b_rdata1 !== exp_rd(raddr1, 1'b1)) begin
                n_mis++; $display("FAIL rand_rd1 cyc=%0d addr=%0d got=%h exp=%h", c, raddr1, b_rdata1, exp_rd(raddr1, 1'b1));
            end
            n_cmp++; if (b_rdata2 !== exp_rd(raddr2, 1'b1)) begin
                n_mis++; $display("FAIL rand_rd2 cyc=%0d addr=%0d got=%h exp=%h", c, raddr2, b_rdata2, exp_rd(raddr2, 1'b1));
            end
            n_cmp++; if (n_rdata1 !== exp_rd(raddr1, 1'b0)) begin
                n_mis++; $display("FAIL rand_rd1_nb cyc=%0d addr=%0d got=%h exp=%h", c, raddr1, n_rdata1, exp_rd(raddr1, 1'b0));
            end
            n_cmp++; if (n_rdata2 !== exp_rd(raddr2, 1'b0)) begin
                n_mis++; $display("FAIL rand_rd2_nb cyc=%0d addr=%0d got=%h exp=%h", c, raddr2, n_rdata2, exp_rd(raddr2, 1'b0));
            end
            n_cmp++; if (b_dbg !== exp_dbg(dbg_addr) || n_dbg !== exp_dbg(dbg_addr)) begin
                n_mis++; $display("FAIL rand_dbg cyc=%0d addr=%0d got=%h/%h exp=%h", c, dbg_addr, b_dbg, n_dbg, exp_dbg(dbg_addr));
            end
            n_cmp++; if (b_cnt !== 16'(m_cnt) || n_cnt !== 16'(m_cnt)) begin
                n_mis++; $display("FAIL rand_cnt cyc=%0d got=%h/%h exp=%h", c, b_cnt, n_cnt, 16'(m_cnt));
            end
            tick();
        end
        idle_inputs();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_saturation();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        we = 1'b1;
        for (int i = 0; i < 65536 + 4; i++) begin
            waddr = 5'((i % 31) + 1);
            wdata = $urandom;
            tick();
            if (i == 65533 || i == 65534 || i == 65535 + 3) begin
                n_cmp++; if (b_cnt !== 16'(m_cnt)) begin
                    n_mis++; $display("FAIL sat_cnt writes=%0d got=%h exp=%h", i + 1, b_cnt, 16'(m_cnt));
                end
            end
        end
        idle_inputs();
        #1;
        n_cmp++; if (b_cnt !== 16'hFFFF || n_cnt !== 16'hFFFF) begin
            n_mis++; $display("FAIL sat_final got=%h/%h exp=ffff", b_cnt, n_cnt);
        end
        for (int a = 1; a < NR; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(a); dbg_addr = 5'(a);
            #1;
            n_cmp++; if (b_rdata1 !== m_regs[a] || b_rdata2 !== m_regs[a] || b_dbg !== m_regs[a]) begin
                n_mis++; $display("FAIL sat_data addr=%0d got=%h/%h/%h exp=%h", a, b_rdata1, b_rdata2, b_dbg, m_regs[a]);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        idle_inputs();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_cnt = 0;
        test_reset();
        test_basic_write();
        test_r0();
        test_bypass();
        test_reset_vs_write();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- General-purpose register file of the MIPS-style CPU, directly downstream of the 5-bit destination-register select mux (rt/rd choice).
- Consumes the selected write address plus write-back data and enable.
- Provides two combinational read ports to decode/execute and one debug read port for board display.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, width of each register and of all data ports
- ADDR_W, 5, register address width; register count = 2**ADDR_W (32)
- BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = reads return stored contents only

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- raddr1  input  ADDR_W  read port 1 address (rs)
- raddr2  input  ADDR_W  read port 2 address (rt)
- rdata1  output  DATA_W  read port 1 data
- rdata2  output  DATA_W  read port 2 data
- we  input  1  write enable from write-back control (RegWrite)
- waddr  input  ADDR_W  write address, output of the destination-select mux
- wdata  input  DATA_W  write-back data (ALU result or memory load)
- dbg_addr  input  ADDR_W  debug read address
- dbg_data  output  DATA_W  debug read data; never bypassed
- wr_cnt  output  16  count of committed writes since reset, saturating

Behaviour:
- Storage: 2**ADDR_W registers of DATA_W bits. Entry 0 is not a flop; it always reads 0.
- Reset:
  - rst=1 at a rising edge clears all registers 1..31 to 0 and wr_cnt to 0.
  - rst has priority over a write in the same cycle; that write is dropped.
  - Reset asserted mid-operation takes effect at the next edge only; combinational outputs keep following the current contents until then.
  - After any reset edge, rdata1, rdata2 and dbg_data are 0 for every address, unless bypass applies.
- Write:
  - Commits on the rising edge when rst=0, we=1 and waddr!=0: reg[waddr] <= wdata.
  - we=1 with waddr=0 is a no-op: register 0 stays 0 and wr_cnt does not increment.
- wr_cnt:
  - Increments by 1 on each committed write.
  - Holds at 16'hFFFF once reached; no wrap.
- Read ports 1/2 (combinational, zero latency):
  - Address 0 returns 0.
  - Otherwise, if BYPASS=1 and we=1 and rst=0 and waddr==raddrN, the port returns wdata (the value being written this cycle).
  - Otherwise the port returns reg[raddrN].
  - Both ports may address the same register; both receive identical data.
- Debug port: dbg_data = reg[dbg_addr], or 0 for address 0. It never reflects the in-flight write; the new value appears after the edge.
- BYPASS=0: reads return pre-edge contents and the new value is visible the cycle after the write edge. Pipeline integration relies on the write-first-half/read-second-half equivalence that BYPASS=1 provides.
- No X propagation: every output is defined for every address after the first reset edge.

Test Plan:
- Reset clear: preload reg5=32'hDEADBEEF, assert rst for 1 cycle -> raddr1=5 gives rdata1=0, dbg_data@5=0, wr_cnt=0.
- Basic write/read: we=1, waddr=8, wdata=32'h12345678, then one edge -> rdata1@8=rdata2@8=dbg_data@8=32'h12345678, wr_cnt=1.
- R0 protection: we=1, waddr=0, wdata=32'hFFFFFFFF -> rdata1@0=0 both during and after the edge, wr_cnt unchanged.
- Bypass:
  - With reg3=32'h1111, drive we=1, waddr=3, wdata=32'h2222, raddr2=3 in the same cycle -> rdata2=32'h2222 before the edge and dbg_data@3=32'h1111 before the edge.
  - Both read 32'h2222 after the edge.
  - With BYPASS=0, rdata2=32'h1111 before the edge.
- Reset vs write: rst=1 and we=1, waddr=9, wdata=32'hABCD on the same edge -> reg9=0, wr_cnt=0.
- Counter saturation: force 65536 committed writes to rotating addresses 1..31 -> wr_cnt stops at 16'hFFFF, register data is still correct.
